lcd_frame_gen: RTL and testbench

Parametrised frame timing generator for the memory-in-pixel LCD parallel port. It drives `o_data`/`o_valid`/`o_update`/`o_invert` with line and frame blanking and alternates DC-balancing polarity. Pixel words come from an upstream ready/valid stream instead of hard-wired pattern logic. It sits between the pixel source (framebuffer reader) and the panel pins, alongside `lcd_tcvr`, which handles the serial register interface.

---
 rtl/lcd_timing_pkg.sv | 16 +
 rtl/lcd_test_pattern.sv | 30 +++
 rtl/lcd_frame_gen.sv | 199 +++++++++++++++++++
 tb/tb_lcd_frame_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared frame-timing definitions for the memory-in-pixel LCD port.
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PORCH  = 2'd2
    } lcd_state_t;

    // Clocks per frame: all lines (active + blank words) plus back porch.
    function automatic int frame_len(input int words_per_line, input int line_blank,
                                     input int lines, input int back_porch);
        return lines * (words_per_line + line_blank) + back_porch;
    endfunction

endpackage

// File: rtl/lcd_test_pattern.sv
// Built-in test pattern: a bright cross, all-ones inside the middle half
// of the line or inside the middle half of the frame, zero elsewhere.
module lcd_test_pattern
    import lcd_timing_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 40,
    parameter int LINES          = 1280,
    parameter int WORD_W         = 6,
    parameter int LINE_W         = 11
) (
    input  logic [WORD_W-1:0] word_idx,
    input  logic [LINE_W-1:0] line_idx,
    output logic [DATA_W-1:0] pattern
);

    localparam int W_LO = WORDS_PER_LINE / 4;
    localparam int W_HI = (3 * WORDS_PER_LINE) / 4;
    localparam int L_LO = LINES / 4;
    localparam int L_HI = (3 * LINES) / 4;

    // Open intervals on both axes.
    always_comb begin
        pattern = '0;
        if ((int'(word_idx) > W_LO && int'(word_idx) < W_HI) ||
            (int'(line_idx) > L_LO && int'(line_idx) < L_HI))
            pattern = '1;
    end

endmodule

// File: rtl/lcd_frame_gen.sv
// Frame timing generator for the memory-in-pixel LCD parallel port.
// Build option: LCD_TEST_PATTERN_EN replaces the pixel stream with the
// internal test pattern (stream ignored, ready held low, no underflow).
//
// state  | meaning
// IDLE   | stopped, all outputs low, waiting for i_enable
// ACTIVE | LINES lines of active + blank words
// PORCH  | back porch; polarity toggles and enable is resampled at its end
module lcd_frame_gen
    import lcd_timing_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 40,
    parameter int LINE_BLANK     = 4,
    parameter int LINES          = 1280,
    parameter int BACK_PORCH     = 24,
    parameter int UPDATE_LEN     = 48,
    parameter int INVERT_HOLD    = 72
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_balance,
    input  logic              i_clr_status,
    input  logic [DATA_W-1:0] i_pix_data,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_update,
    output logic              o_invert,
    output logic              o_sof,
    output logic              o_busy,
    output logic              o_underflow
);

    localparam int LINE_LEN  = WORDS_PER_LINE + LINE_BLANK;
    localparam int FRAME_LEN = frame_len(WORDS_PER_LINE, LINE_BLANK, LINES, BACK_PORCH);
    localparam int WORD_W    = (LINE_LEN > 1)  ? $clog2(LINE_LEN)  : 1;
    localparam int LINE_W    = (LINES > 1)     ? $clog2(LINES)     : 1;
    localparam int FRAME_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(LINE_LEN - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(LINES - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_LEN - 1);

    if (UPDATE_LEN >= FRAME_LEN || INVERT_HOLD >= FRAME_LEN) begin : g_bad_pulse_len
        $error("lcd_frame_gen: UPDATE_LEN and INVERT_HOLD must be shorter than a frame");
    end
    if (WORDS_PER_LINE < 1 || LINES < 1) begin : g_bad_geometry
        $error("lcd_frame_gen: WORDS_PER_LINE and LINES must be at least 1");
    end
    if (BACK_PORCH < 1) begin : g_bad_porch
        $error("lcd_frame_gen: BACK_PORCH must be at least 1 (polarity flips in the porch)");
    end

    lcd_state_t         state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [FRAME_W-1:0] fcyc_q, fcyc_d;
    logic               pol_q, pol_d;   // 1 = inverted frame
    logic               bal_q, bal_d;   // i_balance latched at frame start
    logic [DATA_W-1:0]  pix_word;
    logic               nxt_active_data;

    // State, position counters and frame attributes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            line_q  <= '0;
            fcyc_q  <= '0;
            pol_q   <= 1'b0;
            bal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            line_q  <= line_d;
            fcyc_q  <= fcyc_d;
            pol_q   <= pol_d;
            bal_q   <= bal_d;
        end
    end

    // Next position in the frame; enable/balance only matter at frame boundaries.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        line_d  = line_q;
        fcyc_d  = fcyc_q;
        pol_d   = pol_q;
        bal_d   = bal_q;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_ACTIVE;
                    word_d  = '0;
                    line_d  = '0;
                    fcyc_d  = '0;
                    pol_d   = 1'b0;
                    bal_d   = i_balance;
                end
            end
            ST_ACTIVE: begin
                fcyc_d = fcyc_q + 1'b1;
                if (word_q == WORD_LAST) begin
                    word_d = '0;
                    if (line_q == LINE_LAST) begin
                        line_d  = '0;
                        state_d = ST_PORCH;
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            ST_PORCH: begin
                if (fcyc_q == FRAME_LAST) begin
                    fcyc_d = '0;
                    pol_d  = ~pol_q;
                    if (i_enable) begin
                        state_d = ST_ACTIVE;
                        bal_d   = i_balance;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    fcyc_d = fcyc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Panel bus decode from the current position.
    always_comb begin
        o_busy   = (state_q != ST_IDLE);
        o_sof    = (state_q == ST_ACTIVE) && (fcyc_q == '0);
        o_update = o_busy && (int'(fcyc_q) < UPDATE_LEN);
        o_invert = (pol_q && state_q == ST_PORCH) ||
                   (!pol_q && o_busy && int'(fcyc_q) < INVERT_HOLD);
        o_valid  = (state_q == ST_ACTIVE) && (int'(word_q) < WORDS_PER_LINE) &&
                   (!bal_q || !pol_q);
        o_data   = o_valid ? pix_word : '0;
    end

    // Lookahead: the next cycle is an active word of a data frame.
    always_comb begin
        nxt_active_data = !i_reset && (state_d == ST_ACTIVE) &&
                          (int'(word_d) < WORDS_PER_LINE) && (!bal_d || !pol_d);
    end

`ifdef LCD_TEST_PATTERN_EN
    logic unused_stream;

    assign unused_stream = ^{i_pix_data, i_pix_valid, i_clr_status, nxt_active_data};
    assign o_pix_ready   = 1'b0;
    assign o_underflow   = 1'b0;

    lcd_test_pattern #(
        .DATA_W        (DATA_W),
        .WORDS_PER_LINE(WORDS_PER_LINE),
        .LINES         (LINES),
        .WORD_W        (WORD_W),
        .LINE_W        (LINE_W)
    ) u_pattern (
        .word_idx(word_q),
        .line_idx(line_q),
        .pattern (pix_word)
    );
`else
    logic [DATA_W-1:0] data_q;
    logic              uf_q;

    assign o_pix_ready = nxt_active_data;
    assign pix_word    = data_q;
    assign o_underflow = uf_q;

    // Capture the accepted word; a starved slot still goes out, as zeros.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            data_q <= '0;
        else if (o_pix_ready)
            data_q <= i_pix_valid ? i_pix_data : '0;
    end

    // Sticky underflow; a new underflow beats a simultaneous clear.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            uf_q <= 1'b0;
        else if (o_pix_ready && !i_pix_valid)
            uf_q <= 1'b1;
        else if (i_clr_status)
            uf_q <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_lcd_frame_gen.sv
// Directed bench for lcd_frame_gen with small frame geometry (F = 23).
module tb_lcd_frame_gen;

    localparam int DW = 16;
    localparam int F  = 23;

    logic          i_clock, i_reset, i_enable, i_balance, i_clr_status, i_pix_valid;
    logic [DW-1:0] i_pix_data, o_data;
    logic          o_pix_ready, o_valid, o_update, o_invert, o_sof, o_busy, o_underflow;

    lcd_frame_gen #(
        .DATA_W(DW), .WORDS_PER_LINE(4), .LINE_BLANK(2), .LINES(3),
        .BACK_PORCH(5), .UPDATE_LEN(3), .INVERT_HOLD(4)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_balance(i_balance), .i_clr_status(i_clr_status),
        .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid),
        .o_pix_ready(o_pix_ready), .o_data(o_data), .o_valid(o_valid),
        .o_update(o_update), .o_invert(o_invert), .o_sof(o_sof),
        .o_busy(o_busy), .o_underflow(o_underflow)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Per-frame-cycle expectations: sof, update, invert (normal / inverted frame), active word.
    typedef struct {
        bit sof;
        bit upd;
        bit inv_n;
        bit inv_i;
        bit act;
    } row_t;

    row_t          tbl[F];
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] next_pix;
    bit            exp_uf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input bit exp_ready);
        chk({tag, " busy"},      32'(o_busy),      0);
        chk({tag, " sof"},       32'(o_sof),       0);
        chk({tag, " update"},    32'(o_update),    0);
        chk({tag, " invert"},    32'(o_invert),    0);
        chk({tag, " valid"},     32'(o_valid),     0);
        chk({tag, " data"},      32'(o_data),      0);
        chk({tag, " ready"},     32'(o_pix_ready), 32'(exp_ready));
        chk({tag, " underflow"}, 32'(o_underflow), 32'(exp_uf));
    endtask

    task automatic idle_check(input bit en, input bit bal);
        @(negedge i_clock);
        i_enable = en; i_balance = bal; i_pix_valid = 1'b1;
        i_pix_data = next_pix; i_clr_status = 1'b0;
        #1;
        chk_quiet("idle", en);
        if (en) begin
            sb_q.push_back(next_pix);
            next_pix++;
        end
    endtask

    // Runs ncyc cycles of one frame starting at frame cycle 0.
    task automatic run_frame(input bit pol, input bit bal, input bit nbal, input int ncyc,
                             input int drop_fc, input int clr_fc, input int en_off_fc);
        int            nval;
        bit            dfr, ev, er;
        logic [DW-1:0] ed;
        string         t;
        nval = 0;
        dfr  = !bal || !pol;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge i_clock);
            i_pix_valid  = (c != drop_fc);
            i_pix_data   = i_pix_valid ? next_pix : 16'hDEAD;
            i_clr_status = (c == clr_fc);
            if (c == 1) i_balance = nbal;
            if (c == en_off_fc) i_enable = 1'b0;
            #1;
            t  = $sformatf("pol%0d bal%0d fc%0d", pol, bal, c);
            ev = tbl[c].act && dfr;
            if (c < F - 1) er = tbl[c+1].act && dfr;
            else           er = i_enable && (!i_balance || pol);
            ed = '0;
            if (ev) begin
                chk({t, " sb_nonempty"}, 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) ed = sb_q.pop_front();
            end
            chk({t, " sof"},       32'(o_sof),       32'(tbl[c].sof));
            chk({t, " update"},    32'(o_update),    32'(tbl[c].upd));
            chk({t, " invert"},    32'(o_invert),    32'(pol ? tbl[c].inv_i : tbl[c].inv_n));
            chk({t, " valid"},     32'(o_valid),     32'(ev));
            chk({t, " data"},      32'(o_data),      32'(ed));
            chk({t, " ready"},     32'(o_pix_ready), 32'(er));
            chk({t, " busy"},      32'(o_busy),      1);
            chk({t, " underflow"}, 32'(o_underflow), 32'(exp_uf));
            if (o_valid) nval++;
            if (er) begin
                sb_q.push_back(i_pix_valid ? next_pix : '0);
                if (i_pix_valid) next_pix++;
            end
            if (er && !i_pix_valid) exp_uf = 1'b1;
            else if (i_clr_status)  exp_uf = 1'b0;
        end
        if (ncyc == F)
            chk($sformatf("pol%0d bal%0d valid_words", pol, bal), 32'(nval), dfr ? 12 : 0);
    endtask

    initial begin
        //          sof upd inv_n inv_i act
        tbl[0]  = '{1, 1, 1, 0, 1};
        tbl[1]  = '{0, 1, 1, 0, 1};
        tbl[2]  = '{0, 1, 1, 0, 1};
        tbl[3]  = '{0, 0, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 1};
        tbl[15] = '{0, 0, 0, 0, 1};
        tbl[16] = '{0, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 1, 0};
        tbl[19] = '{0, 0, 0, 1, 0};
        tbl[20] = '{0, 0, 0, 1, 0};
        tbl[21] = '{0, 0, 0, 1, 0};
        tbl[22] = '{0, 0, 0, 1, 0};

        i_reset = 1'b1; i_enable = 1'b0; i_balance = 1'b1; i_clr_status = 1'b0;
        i_pix_valid = 1'b0; i_pix_data = '0;
        next_pix = 16'h0100; exp_uf = 1'b0;

        repeat (2) @(negedge i_clock);
        #1;
        chk_quiet("reset", 1'b0);
        @(negedge i_clock);
        i_reset = 1'b0;

        idle_check(1'b0, 1'b1);
        idle_check(1'b1, 1'b1);

        // Balanced run: data / blank alternate; underflow on 2nd word of frame 2.
        run_frame(1'b0, 1'b1, 1'b1, F, -1, -1, -1);
        run_frame(1'b1, 1'b1, 1'b1, F, -1, -1, -1);
        run_frame(1'b0, 1'b1, 1'b1, F,  0, -1, -1);
        run_frame(1'b1, 1'b1, 1'b0, F, -1,  5, -1);
        // Unbalanced: every frame carries data, polarity still alternates.
        run_frame(1'b0, 1'b0, 1'b0, F,  0,  0, -1);
        run_frame(1'b1, 1'b0, 1'b0, F, -1,  3, -1);
        // Enable drops at cycle 7: frame completes then idles.
        run_frame(1'b0, 1'b0, 1'b0, F, -1, -1,  7);
        idle_check(1'b0, 1'b1);
        idle_check(1'b1, 1'b1);
        // Restart is normal polarity; reset lands at frame cycle 10.
        run_frame(1'b0, 1'b1, 1'b1, 10, -1, -1, -1);
        @(negedge i_clock);
        i_reset = 1'b1; i_enable = 1'b0;
        @(negedge i_clock);
        #1;
        sb_q.delete();
        exp_uf = 1'b0;
        chk_quiet("after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
